pipe_hazard_ctrl: RTL

- Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline.
- Sits beside the decode stage. Tracks destination registers of in-flight instructions in an internal shift register of PIPE_DEPTH slots; slot 0 is execute, slot PIPE_DEPTH-1 is writeback.
- Selects forwarded operands, stalls on load-use hazards and squashes wrong-path instructions on redirect.
- Generalises the fixed two-enable stall scheme to any pipeline depth and load latency, with bubble insertion.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/fwd_select.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Register-address width held in a tracked slot entry.
  localparam int unsigned SLOT_RD_W = 5;

  // Operand source select: 0 = register file, SRC_SLOT_BASE + k = slot k.
  localparam int unsigned SRC_RF        = 0;
  localparam int unsigned SRC_SLOT_BASE = 1;

  // Canonical NOP (addi x0, x0, 0) that the fetch->decode flop holds after a flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 we;
    logic                 is_load;
  } slot_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of rs,
// falls back to register-file data, and flags a producer that is a load whose
// result is not yet available.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int REGISTER_SIZE   = 5,
  parameter int PIPE_DEPTH      = 3,
  parameter int LOAD_READY_SLOT = 2,
  parameter int SRC_W           = $clog2(PIPE_DEPTH + 1)
) (
  input  slot_t [PIPE_DEPTH-1:0]      slots,
  input  logic  [REGISTER_SIZE-1:0]   rs,
  input  logic                        rs_used,
  input  logic  [XLEN-1:0]            rf_data,
  input  logic  [PIPE_DEPTH*XLEN-1:0] stage_data,
  output logic  [XLEN-1:0]            data,
  output logic  [SRC_W-1:0]           src,
  output logic                        not_ready
);

  logic rs_live;

  assign rs_live = rs_used & (rs != '0);

  // Scan oldest to youngest so the lowest-index match overrides older ones.
  always_comb begin
    data      = rf_data;
    src       = SRC_W'(SRC_RF);
    not_ready = 1'b0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (rs_live && slots[k].valid && slots[k].we &&
          (slots[k].rd == SLOT_RD_W'(rs))) begin
        data      = stage_data[k*XLEN +: XLEN];
        src       = SRC_W'(SRC_SLOT_BASE + k);
        not_ready = slots[k].is_load && (k < LOAD_READY_SLOT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller beside the decode stage.
// Tracks destinations of PIPE_DEPTH post-decode slots (0 = EX .. PIPE_DEPTH-1 = WB),
// stalls decode on load-use, forwards operands and squashes on redirect.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int REGISTER_SIZE   = 5,
  parameter int PIPE_DEPTH      = 3,
  parameter int LOAD_READY_SLOT = 2,
  parameter int SRC_W           = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_valid,
  input  logic [REGISTER_SIZE-1:0]   dec_rs1,
  input  logic [REGISTER_SIZE-1:0]   dec_rs2,
  input  logic                       dec_rs1_used,
  input  logic                       dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0]   dec_rd,
  input  logic                       dec_rd_we,
  input  logic                       dec_is_load,
  input  logic [XLEN-1:0]            rf_rs1_data,
  input  logic [XLEN-1:0]            rf_rs2_data,
  input  logic [PIPE_DEPTH*XLEN-1:0] stage_data,
  input  logic                       redirect,
  output logic                       fd_enable,
  output logic                       de_bubble,
  output logic                       fd_flush,
  output logic [XLEN-1:0]            op_a_data,
  output logic [XLEN-1:0]            op_b_data,
  output logic [SRC_W-1:0]           op_a_src,
`ifdef HAZARD_PERF_EN
  output logic [SRC_W-1:0]           op_b_src,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_cycles
`else
  output logic [SRC_W-1:0]           op_b_src
`endif
);

  slot_t [PIPE_DEPTH-1:0] slots_q, slots_d;

  logic [XLEN-1:0]  fwd_a_data, fwd_b_data;
  logic [SRC_W-1:0] fwd_a_src, fwd_b_src;
  logic             nr_a, nr_b;
  logic             stall, issue;

  fwd_select #(
    .XLEN(XLEN), .REGISTER_SIZE(REGISTER_SIZE), .PIPE_DEPTH(PIPE_DEPTH),
    .LOAD_READY_SLOT(LOAD_READY_SLOT), .SRC_W(SRC_W)
  ) u_fwd_a (
    .slots(slots_q), .rs(dec_rs1), .rs_used(dec_rs1_used), .rf_data(rf_rs1_data),
    .stage_data(stage_data), .data(fwd_a_data), .src(fwd_a_src), .not_ready(nr_a)
  );

  fwd_select #(
    .XLEN(XLEN), .REGISTER_SIZE(REGISTER_SIZE), .PIPE_DEPTH(PIPE_DEPTH),
    .LOAD_READY_SLOT(LOAD_READY_SLOT), .SRC_W(SRC_W)
  ) u_fwd_b (
    .slots(slots_q), .rs(dec_rs2), .rs_used(dec_rs2_used), .rf_data(rf_rs2_data),
    .stage_data(stage_data), .data(fwd_b_data), .src(fwd_b_src), .not_ready(nr_b)
  );

  // A redirect squashes the decode instruction, so it overrides any stall.
  assign stall = dec_valid & (nr_a | nr_b) & ~redirect & ~rst;
  assign issue = dec_valid & ~stall & ~redirect & ~rst;

  // Advance the slot shift register; slot 0 takes the issued instruction or a bubble.
  always_comb begin
    slots_d = '0;
    if (!rst) begin
      if (issue) begin
        slots_d[0] = '{valid: 1'b1, rd: SLOT_RD_W'(dec_rd),
                       we: dec_rd_we, is_load: dec_is_load};
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        slots_d[k] = slots_q[k-1];
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  // Pipeline control and operand outputs, zero-latency from slot state and decode.
  always_comb begin
    fd_enable = 1'b1;
    de_bubble = 1'b0;
    fd_flush  = 1'b0;
    op_a_data = fwd_a_data;
    op_b_data = fwd_b_data;
    op_a_src  = fwd_a_src;
    op_b_src  = fwd_b_src;
    if (rst) begin
      de_bubble = 1'b1;
      op_a_data = rf_rs1_data;
      op_b_data = rf_rs2_data;
      op_a_src  = SRC_W'(SRC_RF);
      op_b_src  = SRC_W'(SRC_RF);
    end else if (redirect) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (stall) begin
      fd_enable = 1'b0;
      de_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  // Saturating event counters for stalled and redirected cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (rst) begin
      stall_cycles_d = '0;
      flush_cycles_d = '0;
    end else begin
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
      if (redirect && (flush_cycles_q != 32'hFFFF_FFFF)) flush_cycles_d = flush_cycles_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
    flush_cycles_q <= flush_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule
